// File: rtl/ex_bypass_network_pkg.sv
// Shared types for the EX-stage bypass network: SIMD lane sizes, load
// interlock FSM encoding and the writeback history entry.
package ex_bypass_network_pkg;

    localparam logic [1:0] SIMD8  = 2'b00;
    localparam logic [1:0] SIMD16 = 2'b01;
    localparam logic [1:0] SIMD32 = 2'b10;
    localparam logic [1:0] SIMD64 = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_WAIT = 2'd1,
        LD_HELD = 2'd2
    } ld_state_t;

    // Entries are sized for the widest supported configuration; the top
    // zero-extends on write and truncates on read.
    localparam int HIST_MAX_XLEN = 128;
    localparam int HIST_MAX_AW   = 8;

    typedef struct packed {
        logic                     valid;
        logic [HIST_MAX_AW-1:0]   addr;
        logic [HIST_MAX_XLEN-1:0] data;
    } hist_ent_t;

endpackage

// File: rtl/ex_bypass_network_simd_lane_shuffle.sv
// Horizontal lane pairing and per-lane masking for the rs1/rs2 operand pair.
module simd_lane_shuffle
    import ex_bypass_network_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            simd_ena,
    input  logic            mask_ena,
    input  logic [2:0]      funct3,
    input  logic [XLEN/8-1:0] mask,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic [XLEN-1:0] rs1_sh,
    output logic [XLEN-1:0] rs2_sh
);

    logic [XLEN-1:0] p1, p2, m;

    always_comb begin
        p1 = rs1;
        p2 = rs2;
        if (simd_ena && funct3[2]) begin
            case (funct3[1:0])
                SIMD8: for (int j = 0; j < XLEN/16; j++) begin
                    p1[16*j +: 8]   = rs2[16*j+8 +: 8];
                    p2[16*j+8 +: 8] = rs1[16*j +: 8];
                end
                SIMD16: for (int j = 0; j < XLEN/32; j++) begin
                    p1[32*j +: 16]    = rs2[32*j+16 +: 16];
                    p2[32*j+16 +: 16] = rs1[32*j +: 16];
                end
                SIMD32: for (int j = 0; j < XLEN/64; j++) begin
                    p1[64*j +: 32]    = rs2[64*j+32 +: 32];
                    p2[64*j+32 +: 32] = rs1[64*j +: 32];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        m = {XLEN{mask[0]}};
        case (funct3[1:0])
            SIMD8:  for (int k = 0; k < XLEN/8; k++)  m[8*k +: 8]   = {8{mask[k]}};
            SIMD16: for (int k = 0; k < XLEN/16; k++) m[16*k +: 16] = {16{mask[k]}};
            SIMD32: for (int k = 0; k < XLEN/32; k++) m[32*k +: 32] = {32{mask[k]}};
            default: ;
        endcase
    end

    assign rs1_sh = (simd_ena && mask_ena) ? (p1 & m) : p1;
    assign rs2_sh = (simd_ena && mask_ena) ? (p2 & m) : p2;

endmodule

// File: rtl/ex_bypass_network.sv
// EX-stage operand bypass with WB history buffer, SIMD operand shuffle and
// load-use interlock.
module ex_bypass_network
    import ex_bypass_network_pkg::*;
#(
    parameter int XLEN          = 64,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int NUM_SRC       = 3,
    parameter int HIST_DEPTH    = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_SRC*RF_ADDR_WIDTH-1:0] IDEX_RsAddr,
    input  logic [NUM_SRC*XLEN-1:0]          RF_RsData,
    input  logic                             IDEX_Valid,
    input  logic                             IDEX_Advance,
    input  logic                             simd_ena,
    input  logic                             mask_ena,
    input  logic [2:0]                       funct3,
    input  logic [XLEN/8-1:0]                mask,
    input  logic [RF_ADDR_WIDTH-1:0]         EXMem_RdAddr,
    input  logic                             EXMem_RdWrtEN,
    input  logic [XLEN-1:0]                  EXMem_AluData,
    input  logic                             Mem_LdEN,
    input  logic [XLEN-1:0]                  Dcache_DataRd,
    input  logic                             Dcache_Valid,
    input  logic [RF_ADDR_WIDTH-1:0]         WB_RdAddr,
    input  logic                             WB_RdWrtEN,
    input  logic [XLEN-1:0]                  WB_Data,
    output logic [NUM_SRC*XLEN-1:0]          EXHazard_RsData,
    output logic                             Hazard_Stall,
    output logic [CNT_WIDTH-1:0]             Hazard_StallCnt
);

    localparam int HD = (HIST_DEPTH > 0) ? HIST_DEPTH : 1;

    hist_ent_t       hist [HD];
    ld_state_t       state_q, state_d;
    logic [XLEN-1:0] ld_hold, ld_data;
    logic            post_rst, stall, hold_en;

    logic [NUM_SRC-1:0][XLEN-1:0] fwd, ops;
    logic [NUM_SRC-1:0]           ld_hit;
    logic [RF_ADDR_WIDTH-1:0]     a;
    logic [XLEN-1:0]              rs1_sh, rs2_sh;

    generate
        if (HIST_DEPTH > 0) begin : g_hist
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int h = 0; h < HD; h++) hist[h] <= '0;
                end else if (WB_RdWrtEN) begin
                    hist[0] <= '{valid: 1'b1,
                                 addr:  HIST_MAX_AW'(WB_RdAddr),
                                 data:  HIST_MAX_XLEN'(WB_Data)};
                    for (int h = 1; h < HD; h++) hist[h] <= hist[h-1];
                end
            end
        end else begin : g_no_hist
            always_ff @(posedge clk) hist[0] <= '0;
        end
    endgenerate

    assign ld_data = (state_q == LD_HELD) ? ld_hold : Dcache_DataRd;

    // Later assignments win, so the oldest source is applied first.
    always_comb begin
        fwd    = '0;
        ld_hit = '0;
        a      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            a      = IDEX_RsAddr[i*RF_ADDR_WIDTH +: RF_ADDR_WIDTH];
            fwd[i] = RF_RsData[i*XLEN +: XLEN];
            for (int h = HD-1; h >= 0; h--)
                if (HIST_DEPTH > 0 && a != '0 && hist[h].valid &&
                    hist[h].addr == HIST_MAX_AW'(a))
                    fwd[i] = XLEN'(hist[h].data);
            if (a != '0 && WB_RdWrtEN && WB_RdAddr == a)
                fwd[i] = WB_Data;
            if (a != '0 && EXMem_RdWrtEN && EXMem_RdAddr == a) begin
                fwd[i]    = Mem_LdEN ? ld_data : EXMem_AluData;
                ld_hit[i] = Mem_LdEN;
            end
        end
    end

    simd_lane_shuffle #(.XLEN(XLEN)) u_shuffle (
        .simd_ena (simd_ena),
        .mask_ena (mask_ena),
        .funct3   (funct3),
        .mask     (mask),
        .rs1      (fwd[0]),
        .rs2      (fwd[1]),
        .rs1_sh   (rs1_sh),
        .rs2_sh   (rs2_sh)
    );

    always_comb begin
        ops    = fwd;
        ops[0] = rs1_sh;
        ops[1] = rs2_sh;
    end

    assign EXHazard_RsData = ops;

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        hold_en = 1'b0;
        case (state_q)
            IDLE: if (IDEX_Valid && |ld_hit && !Dcache_Valid) begin
                stall   = 1'b1;
                state_d = LD_WAIT;
            end
            LD_WAIT: begin
                if (!IDEX_Valid) begin
                    state_d = IDLE;
                end else if (Dcache_Valid) begin
                    hold_en = 1'b1;
                    state_d = LD_HELD;
                end else begin
                    stall = 1'b1;
                end
            end
            LD_HELD: if (IDEX_Advance) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // No interlock may start in the first cycle out of reset.
        if (post_rst) begin
            stall   = 1'b0;
            state_d = IDLE;
        end
    end

    assign Hazard_Stall = stall & ~rst;

    always_ff @(posedge clk) begin
        post_rst <= rst;
        if (rst) begin
            state_q         <= IDLE;
            ld_hold         <= '0;
            Hazard_StallCnt <= '0;
        end else begin
            state_q <= state_d;
            if (hold_en) ld_hold <= Dcache_DataRd;
            if (Hazard_Stall && !(&Hazard_StallCnt))
                Hazard_StallCnt <= Hazard_StallCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ex_bypass_network.sv
// Directed checks of forwarding priority, history buffer, load interlock,
// SIMD shuffle/mask and reset behaviour of ex_bypass_network.
module tb_ex_bypass_network;

    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int NS   = 3;
    localparam int HD   = 2;
    localparam int CW   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [NS*AW-1:0]   IDEX_RsAddr;
    logic [NS*XLEN-1:0] RF_RsData;
    logic               IDEX_Valid, IDEX_Advance, simd_ena, mask_ena;
    logic [2:0]         funct3;
    logic [XLEN/8-1:0]  mask;
    logic [AW-1:0]      EXMem_RdAddr, WB_RdAddr;
    logic               EXMem_RdWrtEN, Mem_LdEN, Dcache_Valid, WB_RdWrtEN;
    logic [XLEN-1:0]    EXMem_AluData, Dcache_DataRd, WB_Data;
    logic [NS*XLEN-1:0] EXHazard_RsData;
    logic               Hazard_Stall;
    logic [CW-1:0]      Hazard_StallCnt;

    int checks = 0;
    int errors = 0;

    ex_bypass_network #(
        .XLEN(XLEN), .RF_ADDR_WIDTH(AW), .NUM_SRC(NS),
        .HIST_DEPTH(HD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .IDEX_RsAddr(IDEX_RsAddr), .RF_RsData(RF_RsData),
        .IDEX_Valid(IDEX_Valid), .IDEX_Advance(IDEX_Advance),
        .simd_ena(simd_ena), .mask_ena(mask_ena), .funct3(funct3), .mask(mask),
        .EXMem_RdAddr(EXMem_RdAddr), .EXMem_RdWrtEN(EXMem_RdWrtEN),
        .EXMem_AluData(EXMem_AluData), .Mem_LdEN(Mem_LdEN),
        .Dcache_DataRd(Dcache_DataRd), .Dcache_Valid(Dcache_Valid),
        .WB_RdAddr(WB_RdAddr), .WB_RdWrtEN(WB_RdWrtEN), .WB_Data(WB_Data),
        .EXHazard_RsData(EXHazard_RsData), .Hazard_Stall(Hazard_Stall),
        .Hazard_StallCnt(Hazard_StallCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input logic [AW-1:0] a0, a1, a2);
        IDEX_RsAddr = {a2, a1, a0};
    endtask

    task automatic set_rf(input logic [XLEN-1:0] d0, d1, d2);
        RF_RsData = {d2, d1, d0};
    endtask

    function automatic logic [63:0] op(input int i);
        return EXHazard_RsData[i*XLEN +: XLEN];
    endfunction

    initial begin
        rst = 1'b1;
        IDEX_Valid = 0; IDEX_Advance = 0; simd_ena = 0; mask_ena = 0;
        funct3 = 3'b000; mask = '0;
        EXMem_RdAddr = 0; EXMem_RdWrtEN = 0; EXMem_AluData = 0; Mem_LdEN = 0;
        Dcache_DataRd = 0; Dcache_Valid = 0;
        WB_RdAddr = 0; WB_RdWrtEN = 0; WB_Data = 0;
        set_rs(0, 0, 0);
        set_rf(64'hF0, 64'hF1, 64'hF2);

        // reset state
        tick(); #1;
        check("rst_stall", 64'(Hazard_Stall), 64'd0);
        check("rst_cnt", 64'(Hazard_StallCnt), 64'd0);
        check("rst_rf_op0", op(0), 64'hF0);

        // cycle after reset: a load match must not stall
        rst = 1'b0;
        set_rs(3, 0, 0); IDEX_Valid = 1;
        EXMem_RdAddr = 3; EXMem_RdWrtEN = 1; Mem_LdEN = 1;
        #1;
        check("post_rst_stall", 64'(Hazard_Stall), 64'd0);
        Mem_LdEN = 0; EXMem_RdWrtEN = 0; IDEX_Valid = 0;

        // EX/MEM beats WB, WB beats RF, x0 never forwarded
        tick();
        EXMem_RdAddr = 5; EXMem_RdWrtEN = 1; EXMem_AluData = 64'hAAAA;
        WB_RdAddr = 5; WB_RdWrtEN = 1; WB_Data = 64'h1111;
        set_rs(5, 5, 5); #1;
        check("ex_prio0", op(0), 64'hAAAA);
        check("ex_prio1", op(1), 64'hAAAA);
        check("ex_prio2", op(2), 64'hAAAA);
        EXMem_RdWrtEN = 0; #1;
        check("wb_prio0", op(0), 64'h1111);
        set_rs(0, 0, 0); EXMem_RdAddr = 0; EXMem_RdWrtEN = 1; WB_RdAddr = 0; #1;
        check("x0_rf0", op(0), 64'hF0);
        check("x0_rf2", op(2), 64'hF2);
        EXMem_RdWrtEN = 0; WB_RdWrtEN = 0;

        // history buffer: newest same-address entry wins
        tick();
        WB_RdWrtEN = 1; WB_RdAddr = 7; WB_Data = 64'h1;
        tick(); WB_Data = 64'h2;
        tick(); WB_RdAddr = 9; WB_Data = 64'h9;
        tick(); WB_RdWrtEN = 0;
        set_rs(9, 7, 7); #1;
        check("hist_h0", op(0), 64'h9);
        check("hist_shadow1", op(1), 64'h2);
        check("hist_shadow2", op(2), 64'h2);
        WB_RdWrtEN = 1; WB_RdAddr = 7; WB_Data = 64'h33; #1;
        check("wb_over_hist", op(1), 64'h33);
        WB_RdAddr = 10; WB_Data = 64'hA;
        tick(); WB_RdAddr = 11; WB_Data = 64'hB;
        tick(); WB_RdAddr = 12; WB_Data = 64'hC;
        tick(); WB_RdWrtEN = 0;
        set_rs(12, 7, 0); #1;
        check("hist_young", op(0), 64'hC);
        check("hist_evict", op(1), 64'hF1);

        // load-use: data returns three cycles after the load is seen
        set_rs(3, 0, 0); IDEX_Valid = 1;
        EXMem_RdAddr = 3; EXMem_RdWrtEN = 1; Mem_LdEN = 1; EXMem_AluData = 64'h5555;
        #1;
        check("ld_stall_c0", 64'(Hazard_Stall), 64'd1);
        tick();
        check("ld_stall_c1", 64'(Hazard_Stall), 64'd1);
        check("ld_cnt_c1", 64'(Hazard_StallCnt), 64'd1);
        tick();
        check("ld_stall_c2", 64'(Hazard_Stall), 64'd1);
        check("ld_cnt_c2", 64'(Hazard_StallCnt), 64'd2);
        tick();
        Dcache_Valid = 1; Dcache_DataRd = 64'hDEAD; #1;
        check("ld_ret_stall", 64'(Hazard_Stall), 64'd0);
        check("ld_ret_cnt", 64'(Hazard_StallCnt), 64'd3);
        check("ld_ret_data", op(0), 64'hDEAD);
        tick();
        Dcache_Valid = 0; Dcache_DataRd = 64'h0; #1;
        check("ld_held_data", op(0), 64'hDEAD);
        check("ld_held_stall", 64'(Hazard_Stall), 64'd0);
        IDEX_Advance = 1;
        tick();
        IDEX_Advance = 0;
        Dcache_Valid = 1; Dcache_DataRd = 64'hBEEF; #1;
        check("zero_wait_stall", 64'(Hazard_Stall), 64'd0);
        check("zero_wait_data", op(0), 64'hBEEF);
        tick();
        Dcache_Valid = 0; Mem_LdEN = 0; EXMem_RdWrtEN = 0; IDEX_Valid = 0; #1;
        check("zero_wait_cnt", 64'(Hazard_StallCnt), 64'd3);

        // SIMD shuffle and masking
        set_rs(0, 0, 0);
        set_rf(64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555, 64'hF2);
        simd_ena = 1; funct3 = 3'b101; #1;
        check("h16_rs1", op(0), 64'h4444_8888_2222_6666);
        check("h16_rs2", op(1), 64'h3333_7777_1111_5555);
        check("h16_slot2", op(2), 64'hF2);
        set_rf(64'h0807_0605_0403_0201, 64'h1817_1615_1413_1211, 64'hF2);
        funct3 = 3'b100; #1;
        check("h8_rs1", op(0), 64'h0818_0616_0414_0212);
        check("h8_rs2", op(1), 64'h0717_0515_0313_0111);
        funct3 = 3'b111; #1;
        check("h64_rs1", op(0), 64'h0807_0605_0403_0201);
        simd_ena = 0; funct3 = 3'b101; #1;
        check("nosimd_rs2", op(1), 64'h1817_1615_1413_1211);
        set_rf(64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555, 64'hF2);
        simd_ena = 1; funct3 = 3'b010; mask_ena = 1; mask = 8'b01; #1;
        check("m32_rs1", op(0), 64'h0000_0000_2222_1111);
        check("m32_rs2", op(1), 64'h0000_0000_6666_5555);
        set_rf(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hF2);
        funct3 = 3'b000; mask = 8'hA5; #1;
        check("m8_rs1", op(0), 64'hFF00_FF00_00FF_00FF);
        simd_ena = 0; mask_ena = 0; mask = '0; funct3 = 3'b000;
        set_rf(64'hF0, 64'hF1, 64'hF2);

        // squash: consumer disappears while waiting on the load
        set_rs(3, 0, 0); IDEX_Valid = 1;
        EXMem_RdAddr = 3; EXMem_RdWrtEN = 1; Mem_LdEN = 1; #1;
        check("sq_stall0", 64'(Hazard_Stall), 64'd1);
        tick();
        IDEX_Valid = 0; #1;
        check("sq_stall1", 64'(Hazard_Stall), 64'd0);
        tick();
        IDEX_Valid = 1; #1;
        check("sq_restall", 64'(Hazard_Stall), 64'd1);

        // reset while waiting on a load
        tick();
        check("rw_stall", 64'(Hazard_Stall), 64'd1);
        rst = 1; #1;
        check("rw_rst_stall", 64'(Hazard_Stall), 64'd0);
        tick();
        rst = 0; #1;
        check("rw_after_stall", 64'(Hazard_Stall), 64'd0);
        check("rw_after_cnt", 64'(Hazard_StallCnt), 64'd0);
        tick();
        check("rw_idle_stall", 64'(Hazard_Stall), 64'd1);
        check("rw_idle_cnt", 64'(Hazard_StallCnt), 64'd0);

        IDEX_Valid = 0; Mem_LdEN = 0; EXMem_RdWrtEN = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
